// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle core: opcodes, FSM states, instruction
// field positions and flag bit indices.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_e;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 4;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 12;
  localparam int IMM_LSB = 16;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

endpackage

// File: rtl/cpu_if.sv
// Instruction-fetch and data-access req/ack bus between the core (master)
// and the memory fabric (slave).
interface cpu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_data;
  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_ack, i_data, d_ack, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_ack, i_data, d_ack, d_rdata
  );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU for opcodes 2-7 (and MUL on opcode E when CPU_MUL_EN is
// defined); upd flags the ops that write rd and update Z/C.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c,
  output logic              upd
);
  logic [DATA_W:0] sum;

`ifdef CPU_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    c      = 1'b0;
    upd    = 1'b1;
    case (op)
      OP_ADD, OP_ADDI: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
`ifdef CPU_MUL_EN
      OP_MUL: begin
        result = prod[DATA_W-1:0];
        c      = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: upd = 1'b0;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle core: IDLE -> FETCH -> EXEC -> (MEM) -> FETCH, with req/ack
// fetch and data ports. Opcode E is MUL only when CPU_MUL_EN is defined.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REGS   = 8,
  parameter int ADDR_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  cpu_if.master      bus,
  output logic       halted,
  output logic [7:0] dbg_r0,
  output logic [3:0] dbg_pc
);
  localparam int RI_W = (REGS > 1) ? $clog2(REGS) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [REGS];
  logic [DATA_W-1:0] regs_d [REGS];
  logic [1:0]        flags_q, flags_d;
  logic              i_req_q, i_req_d, d_req_q, d_req_d;
  logic              d_we_q, d_we_d, halted_q, halted_d;
  logic [DATA_W-1:0] d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;

  logic [3:0]        opc, rd, rs1, rs2;
  logic [DATA_W-1:0] imm, rs1_val, rs2_val, alu_b, alu_res, wr_data;
  logic [ADDR_W-1:0] target, pc_inc;
  logic              alu_z, alu_c, alu_upd, wr_en;

  // Out-of-range register indices read as zero.
  function automatic logic [DATA_W-1:0] reg_rd(input logic [3:0] idx);
    if (32'(idx) < REGS) return regs_q[idx[RI_W-1:0]];
    return '0;
  endfunction

  assign opc     = ir_q[OPC_LSB +: 4];
  assign rd      = ir_q[RD_LSB +: 4];
  assign rs1     = ir_q[RS1_LSB +: 4];
  assign rs2     = ir_q[RS2_LSB +: 4];
  assign imm     = DATA_W'(ir_q[IMM_LSB +: 16]);
  assign target  = ir_q[IMM_LSB +: ADDR_W];
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign rs1_val = reg_rd(rs1);
  assign rs2_val = reg_rd(rs2);
  assign alu_b   = (opc == OP_ADDI) ? imm : rs2_val;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (opc),
    .a      (rs1_val),
    .b      (alu_b),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c),
    .upd    (alu_upd)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    flags_d   = flags_q;
    i_req_d   = i_req_q;
    d_req_d   = d_req_q;
    d_we_d    = d_we_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    halted_d  = halted_q;
    wr_en     = 1'b0;
    wr_data   = alu_res;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        i_req_d = 1'b1;
      end
      FETCH: begin
        if (bus.i_ack) begin
          ir_d    = bus.i_data;
          i_req_d = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        i_req_d = 1'b1;
        pc_d    = pc_inc;
        if (alu_upd) begin
          wr_en           = 1'b1;
          flags_d[FLAG_Z] = alu_z;
          flags_d[FLAG_C] = alu_c;
        end
        case (opc)
          OP_MOV: begin
            wr_en   = 1'b1;
            wr_data = imm;
          end
          // PC advances only once the memory access completes.
          OP_LD, OP_ST: begin
            state_d   = MEM;
            i_req_d   = 1'b0;
            pc_d      = pc_q;
            d_req_d   = 1'b1;
            d_we_d    = (opc == OP_ST);
            d_addr_d  = rs1_val + imm;
            d_wdata_d = rs2_val;
          end
          OP_JMP: pc_d = target;
          OP_JZ:  if (flags_q[FLAG_Z]) pc_d = target;
          OP_JC:  if (flags_q[FLAG_C]) pc_d = target;
          OP_HALT: begin
            state_d  = HALT;
            i_req_d  = 1'b0;
            pc_d     = pc_q;
            halted_d = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        if (bus.d_ack) begin
          d_req_d = 1'b0;
          wr_en   = !d_we_q;
          wr_data = bus.d_rdata;
          pc_d    = pc_inc;
          state_d = FETCH;
          i_req_d = 1'b1;
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (32'(rd) < REGS)) regs_d[rd[RI_W-1:0]] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      flags_q   <= '0;
      i_req_q   <= 1'b0;
      d_req_q   <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      halted_q  <= 1'b0;
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      i_req_q   <= i_req_d;
      d_req_q   <= d_req_d;
      d_we_q    <= d_we_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      halted_q  <= halted_d;
      regs_q    <= regs_d;
    end
  end

  assign bus.i_req   = i_req_q;
  assign bus.i_addr  = pc_q;
  assign bus.d_req   = d_req_q;
  assign bus.d_we    = d_we_q;
  assign bus.d_addr  = d_addr_q;
  assign bus.d_wdata = d_wdata_q;
  assign halted      = halted_q;
  assign dbg_r0      = regs_q[0][7:0];
  assign dbg_pc      = pc_q[3:0];

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: expected fetch addresses and data-bus
// transactions are queued per program and matched as the core issues them.
`timescale 1ns/1ps
module tb_cpu_core;
  localparam int DATA_W = 16;
  localparam int REGS   = 8;
  localparam int ADDR_W = 16;

  localparam logic [3:0] NOP = 4'h0, MOV = 4'h1, ADD = 4'h2, ADDI = 4'h3,
                         SUB = 4'h4, XOR = 4'h7, LD = 4'h8, ST = 4'h9,
                         JMP = 4'hA, JZ = 4'hB, JC = 4'hC, HLT = 4'hD;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } dtx_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halted;
  logic [7:0] dbg_r0;
  logic [3:0] dbg_pc;

  cpu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  cpu_core #(.DATA_W(DATA_W), .REGS(REGS), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .halted (halted),
    .dbg_r0 (dbg_r0),
    .dbg_pc (dbg_pc)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [15:0] dmem [256];
  int i_wait = 0, d_wait = 0;
  int i_cnt, d_cnt;
  int checks = 0, errors = 0;
  logic [15:0] exp_i [$];
  dtx_t        exp_d [$];

  assign bus_if.i_ack   = bus_if.i_req && (i_cnt >= i_wait);
  assign bus_if.i_data  = imem[bus_if.i_addr[7:0]];
  assign bus_if.d_ack   = bus_if.d_req && (d_cnt >= d_wait);
  assign bus_if.d_rdata = dmem[bus_if.d_addr[7:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt <= 0;
      d_cnt <= 0;
    end else begin
      i_cnt <= (bus_if.i_req && !bus_if.i_ack) ? i_cnt + 1 : 0;
      d_cnt <= (bus_if.d_req && !bus_if.d_ack) ? d_cnt + 1 : 0;
      if (bus_if.d_req && bus_if.d_ack && bus_if.d_we)
        dmem[bus_if.d_addr[7:0]] <= bus_if.d_wdata;
    end
  end

  // Scoreboard: pop and compare on every completed handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.i_req && bus_if.i_ack) begin
        checks++;
        if (exp_i.size() == 0) begin
          errors++;
          $display("FAIL fetch_unexpected addr=%h required=none", bus_if.i_addr);
        end else begin
          logic [15:0] ea;
          ea = exp_i.pop_front();
          if (bus_if.i_addr !== ea) begin
            errors++;
            $display("FAIL fetch_addr got=%h required=%h", bus_if.i_addr, ea);
          end
        end
      end
      if (bus_if.d_req && bus_if.d_ack) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL dbus_unexpected we=%b addr=%h wdata=%h required=none",
                   bus_if.d_we, bus_if.d_addr, bus_if.d_wdata);
        end else begin
          dtx_t e;
          e = exp_d.pop_front();
          if (bus_if.d_we !== e.we || bus_if.d_addr !== e.addr ||
              (e.we && bus_if.d_wdata !== e.wdata)) begin
            errors++;
            $display("FAIL dbus got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                     bus_if.d_we, bus_if.d_addr, bus_if.d_wdata, e.we, e.addr, e.wdata);
          end
        end
      end
    end
  end

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {imm, rs2, rs1, rd, op};
  endfunction

  task automatic push_d(input logic we, input logic [15:0] a, input logic [15:0] w);
    dtx_t t;
    t.we = we; t.addr = a; t.wdata = w;
    exp_d.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_i.delete();
    exp_d.delete();
    for (int i = 0; i < 256; i++) imem[i] = ins(HLT, 0, 0, 0, 0);
    i_wait = 0;
    d_wait = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_if.i_req !== 1'b0 || bus_if.d_req !== 1'b0 || bus_if.d_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got i=%b d=%b we=%b required 0",
               bus_if.i_req, bus_if.d_req, bus_if.d_we);
    end
    checks++;
    if (bus_if.i_addr !== 16'h0 || bus_if.d_addr !== 16'h0 || bus_if.d_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_bus got i_addr=%h d_addr=%h d_wdata=%h required 0",
               bus_if.i_addr, bus_if.d_addr, bus_if.d_wdata);
    end
    checks++;
    if (halted !== 1'b0 || dbg_r0 !== 8'h0 || dbg_pc !== 4'h0) begin
      errors++;
      $display("FAIL reset_dbg got halted=%b r0=%h pc=%h required 0", halted, dbg_r0, dbg_pc);
    end
  endtask

  task automatic test_basic();
    int  cyc;
    logic any_req;
    do_reset();
    imem[0] = ins(MOV, 1, 0, 0, 16'd5);
    imem[1] = ins(ADDI, 1, 1, 0, 16'd3);
    imem[2] = ins(HLT, 0, 0, 0, 0);
    exp_i.push_back(16'h0); exp_i.push_back(16'h1); exp_i.push_back(16'h2);
    rst = 1'b0;
    run_to_halt(cyc);
    checks++;
    if (halted !== 1'b1 || cyc != 7) begin
      errors++;
      $display("FAIL basic_halt_cycle got halted=%b cycle=%0d required 1 at 7", halted, cyc);
    end
    any_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus_if.i_req !== 1'b0 || bus_if.d_req !== 1'b0) any_req = 1'b1;
    end
    checks++;
    if (any_req !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL basic_after_halt got req_seen=%b halted=%b required 0,1", any_req, halted);
    end
    checks++;
    if (exp_i.size() != 0) begin
      errors++;
      $display("FAIL basic_queue got pending=%0d required 0", exp_i.size());
    end
  endtask

  task automatic test_fetch_wait();
    int cyc;
    logic prev_req, prev_ack;
    logic [15:0] prev_addr;
    do_reset();
    i_wait = 3;
    imem[0] = ins(MOV, 1, 0, 0, 16'd5);
    imem[1] = ins(ADDI, 1, 1, 0, 16'd3);
    imem[2] = ins(ST, 0, 0, 1, 16'h0010);
    imem[3] = ins(HLT, 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) exp_i.push_back(16'(a));
    push_d(1'b1, 16'h0010, 16'h0008);
    rst = 1'b0;
    cyc = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    while (halted !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prev_req && !prev_ack) begin
        checks++;
        if (bus_if.i_req !== 1'b1 || bus_if.i_addr !== prev_addr) begin
          errors++;
          $display("FAIL fetch_hold got req=%b addr=%h required 1 %h",
                   bus_if.i_req, bus_if.i_addr, prev_addr);
        end
      end
      prev_req  = bus_if.i_req;
      prev_ack  = bus_if.i_ack;
      prev_addr = bus_if.i_addr;
    end
    checks++;
    if (halted !== 1'b1 || cyc != 22) begin
      errors++;
      $display("FAIL fetch_wait_cycles got halted=%b cycle=%0d required 1 at 22", halted, cyc);
    end
    checks++;
    if (exp_i.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL fetch_wait_queue got pending=%0d/%0d required 0", exp_i.size(), exp_d.size());
    end
  endtask

  task automatic test_mem();
    int cyc;
    do_reset();
    d_wait = 2;
    imem[0] = ins(MOV, 2, 0, 0, 16'h0020);
    imem[1] = ins(MOV, 3, 0, 0, 16'hBEEF);
    imem[2] = ins(ST, 0, 2, 3, 16'h0001);
    imem[3] = ins(LD, 4, 2, 0, 16'h0001);
    imem[4] = ins(ST, 0, 0, 4, 16'h0030);
    imem[5] = ins(HLT, 0, 0, 0, 0);
    for (int a = 0; a < 6; a++) exp_i.push_back(16'(a));
    push_d(1'b1, 16'h0021, 16'hBEEF);
    push_d(1'b0, 16'h0021, 16'h0000);
    push_d(1'b1, 16'h0030, 16'hBEEF);
    rst = 1'b0;
    run_to_halt(cyc);
    checks++;
    if (halted !== 1'b1 || exp_i.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL mem_done got halted=%b pending=%0d/%0d required 1,0,0",
               halted, exp_i.size(), exp_d.size());
    end
  endtask

  task automatic test_flags();
    int cyc;
    logic [15:0] seq [13] = '{16'h00, 16'h01, 16'h02, 16'h03, 16'h0A, 16'h0B, 16'h0C,
                              16'h0D, 16'h10, 16'h14, 16'h15, 16'h16, 16'h17};
    do_reset();
    imem[8'h00] = ins(MOV, 2, 0, 0, 16'h0001);
    imem[8'h01] = ins(SUB, 3, 1, 2, 16'h0000);
    imem[8'h02] = ins(JZ,  0, 0, 0, 16'h0030);
    imem[8'h03] = ins(JC,  0, 0, 0, 16'h000A);
    imem[8'h0A] = ins(ST,  0, 0, 3, 16'h0040);
    imem[8'h0B] = ins(MOV, 4, 0, 0, 16'hFFFF);
    imem[8'h0C] = ins(ADD, 5, 4, 2, 16'h0000);
    imem[8'h0D] = ins(JZ,  0, 0, 0, 16'h0010);
    imem[8'h10] = ins(JC,  0, 0, 0, 16'h0014);
    imem[8'h14] = ins(ST,  0, 0, 5, 16'h0041);
    imem[8'h15] = ins(XOR, 6, 2, 2, 16'h0000);
    imem[8'h16] = ins(JC,  0, 0, 0, 16'h0030);
    imem[8'h17] = ins(HLT, 0, 0, 0, 0);
    for (int k = 0; k < 13; k++) exp_i.push_back(seq[k]);
    push_d(1'b1, 16'h0040, 16'hFFFF);
    push_d(1'b1, 16'h0041, 16'h0000);
    rst = 1'b0;
    run_to_halt(cyc);
    checks++;
    if (halted !== 1'b1 || exp_i.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL flags_done got halted=%b pending=%0d/%0d required 1,0,0",
               halted, exp_i.size(), exp_d.size());
    end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [15:0] seq [10] = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF, 16'h0000,
                              16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    do_reset();
    imem[8'h00] = ins(JZ,  0, 0, 0, 16'h0003);
    imem[8'h01] = ins(XOR, 1, 1, 1, 16'h0000);
    imem[8'h02] = ins(JMP, 0, 0, 0, 16'hFFFF);
    imem[8'hFF] = ins(NOP, 0, 0, 0, 16'h0000);
    imem[8'h03] = ins(MOV, 4, 0, 0, 16'h0011);
    imem[8'h04] = ins(MOV, 12, 0, 0, 16'h0055);
    imem[8'h05] = ins(ST,  0, 0, 4, 16'h0050);
    imem[8'h06] = ins(ST,  0, 0, 12, 16'h0051);
    imem[8'h07] = ins(HLT, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) exp_i.push_back(seq[k]);
    push_d(1'b1, 16'h0050, 16'h0011);
    push_d(1'b1, 16'h0051, 16'h0000);
    rst = 1'b0;
    run_to_halt(cyc);
    checks++;
    if (halted !== 1'b1 || exp_i.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL wrap_done got halted=%b pending=%0d/%0d required 1,0,0",
               halted, exp_i.size(), exp_d.size());
    end
  endtask

  task automatic test_rst_mid();
    int cyc;
    do_reset();
    d_wait = 10;
    imem[0] = ins(MOV, 0, 0, 0, 16'h0077);
    imem[1] = ins(MOV, 1, 0, 0, 16'h0033);
    imem[2] = ins(ST,  0, 1, 0, 16'h0000);
    for (int a = 0; a < 3; a++) exp_i.push_back(16'(a));
    rst = 1'b0;
    cyc = 0;
    while (bus_if.d_req !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus_if.d_req !== 1'b1 || dbg_r0 !== 8'h77) begin
      errors++;
      $display("FAIL rst_mid_pre got d_req=%b r0=%h required 1 77", bus_if.d_req, dbg_r0);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus_if.d_req !== 1'b0 || bus_if.i_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop got d_req=%b i_req=%b required 0 0", bus_if.d_req, bus_if.i_req);
    end
    checks++;
    if (dbg_pc !== 4'h0 || dbg_r0 !== 8'h00 || exp_i.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_state got pc=%h r0=%h pending=%0d required 0 0 0",
               dbg_pc, dbg_r0, exp_i.size());
    end
    @(negedge clk);
    d_wait = 0;
    imem[0] = ins(ST, 0, 0, 1, 16'h0062);
    imem[1] = ins(HLT, 0, 0, 0, 0);
    imem[2] = ins(HLT, 0, 0, 0, 0);
    exp_i.push_back(16'h0); exp_i.push_back(16'h1);
    push_d(1'b1, 16'h0062, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    run_to_halt(cyc);
    checks++;
    if (halted !== 1'b1 || exp_i.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_restart got halted=%b pending=%0d/%0d required 1,0,0",
               halted, exp_i.size(), exp_d.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fetch_wait();
    test_mem();
    test_flags();
    test_wrap();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
